mux_sel_sequencer: RTL and testbench

- Synchronous scan controller that sits directly upstream of the 4:1 Multiplexer and drives its Sel.
- Steps through the enabled channels and holds each for a programmable dwell.
- Samples the mux output Y at the end of each dwell and assembles a 4-bit frame.
- Presents the frame with a one-cycle valid strobe after every complete scan.

---
 rtl/mux_seq_pkg.sv | 14 +
 rtl/mux_seq_next.sv | 28 ++
 rtl/mux_sel_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mux_sel_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and sizes for the mux select sequencer.
package mux_seq_pkg;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned DWELL_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        WRAP  = 2'd2
    } state_t;

endpackage

// File: rtl/mux_seq_next.sv
// Channel picker: next higher enabled channel after sel, and lowest enabled channel.
module mux_seq_next
    import mux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  sel,
    output logic [SEL_W-1:0]  next_idx,
    output logic              has_next,
    output logic [SEL_W-1:0]  low_idx
);

    // Scan from the top down so the last hit is the lowest qualifying index.
    always_comb begin
        next_idx = sel;
        has_next = 1'b0;
        low_idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SEL_W'(i);
                if (i > int'(sel)) begin
                    next_idx = SEL_W'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scan controller driving the 4:1 mux select; samples Y per channel into a frame.
// Optional: define MUX_SEQ_MAJORITY_EN for 2-of-3 sampling over the last three
// dwell cycles (only when the latched dwell is at least 2).
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               En,
    input  logic [NUM_CH-1:0]  Mask,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Y,
    output logic [SEL_W-1:0]   Sel,
    output logic               Busy,
    output logic [NUM_CH-1:0]  Frame,
    output logic               Frame_vld
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                busy_q, busy_d;
    logic [NUM_CH-1:0]   frame_q, frame_d;
    logic                vld_q, vld_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;

    logic                start_ok;
    logic                dwell_done;
    logic                sample_bit;
    logic [NUM_CH-1:0]   pick_mask;
    logic [SEL_W-1:0]    next_idx;
    logic                has_next;
    logic [SEL_W-1:0]    low_idx;

    assign start_ok   = En && (Mask != '0);
    assign dwell_done = (cnt_q == dwell_q);

    // During a scan walk the latched mask; at latch points pick from the live input.
    assign pick_mask = (state_q == DWELL) ? mask_q : Mask;

    mux_seq_next u_next (
        .mask     (pick_mask),
        .sel      (sel_q),
        .next_idx (next_idx),
        .has_next (has_next),
        .low_idx  (low_idx)
    );

`ifdef MUX_SEQ_MAJORITY_EN
    logic [1:0] hist_q, hist_d;
    logic       maj;

    // 2-of-3 vote over the two previous cycles and the current one.
    always_comb begin
        maj        = (hist_q[1] & hist_q[0]) | (hist_q[1] & Y) | (hist_q[0] & Y);
        sample_bit = (dwell_q >= DWELL_W'(2)) ? maj : Y;
    end
`else
    assign sample_bit = Y;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            frame_q  <= '0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
`ifdef MUX_SEQ_MAJORITY_EN
            hist_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            frame_q  <= frame_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            dwell_q  <= dwell_d;
`ifdef MUX_SEQ_MAJORITY_EN
            hist_q   <= hist_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = DWELL;
            DWELL:   if (dwell_done && !has_next) state_d = WRAP;
            WRAP:    state_d = start_ok ? DWELL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and scan datapath.
    always_comb begin
        sel_d    = sel_q;
        busy_d   = busy_q;
        frame_d  = frame_q;
        vld_d    = 1'b0;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        dwell_d  = dwell_q;
`ifdef MUX_SEQ_MAJORITY_EN
        hist_d   = hist_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mask_d   = Mask;
                    dwell_d  = Dwell;
                    sel_d    = low_idx;
                    cnt_d    = '0;
                    shadow_d = '0;
                    busy_d   = 1'b1;
`ifdef MUX_SEQ_MAJORITY_EN
                    hist_d   = '0;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            DWELL: begin
                if (dwell_done) begin
                    shadow_d[sel_q] = sample_bit;
                    cnt_d           = '0;
`ifdef MUX_SEQ_MAJORITY_EN
                    hist_d          = '0;
`endif
                    if (has_next) sel_d = next_idx;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
`ifdef MUX_SEQ_MAJORITY_EN
                    hist_d = {hist_q[0], Y};
`endif
                end
            end
            WRAP: begin
                frame_d = shadow_q;
                vld_d   = 1'b1;
                if (start_ok) begin
                    mask_d   = Mask;
                    dwell_d  = Dwell;
                    sel_d    = low_idx;
                    cnt_d    = '0;
                    shadow_d = '0;
`ifdef MUX_SEQ_MAJORITY_EN
                    hist_d   = '0;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign Sel       = sel_q;
    assign Busy      = busy_q;
    assign Frame     = frame_q;
    assign Frame_vld = vld_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer: expected frames queued at scan start,
// a monitor pops and checks them whenever Frame_vld is seen.
`timescale 1ns/1ps
module tb_mux_sel_sequencer;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          En;
    logic [3:0]    Mask;
    logic [DW-1:0] Dwell;
    logic          Y;
    logic [1:0]    Sel;
    logic          Busy;
    logic [3:0]    Frame;
    logic          Frame_vld;

    logic [3:0]    ch_data;
    logic          y_force;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] frame;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural 4:1 mux, with a forced-low glitch hook.
    assign Y = y_force ? 1'b0 : ch_data[Sel];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mux_sel_sequencer #(.DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .En        (En),
        .Mask      (Mask),
        .Dwell     (Dwell),
        .Y         (Y),
        .Sel       (Sel),
        .Busy      (Busy),
        .Frame     (Frame),
        .Frame_vld (Frame_vld)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [3:0] f, input int at);
        exp_t e;
        e.frame = f;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every Frame_vld pulse must match the next queued frame and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && Frame_vld !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_vld: Frame_vld=%b Frame=%b with nothing expected (cycle %0d)",
                         Frame_vld, Frame, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("frame", int'(Frame), int'(e.frame));
                chk("vld_cycle", cyc, e.at);
            end
        end
    end

    // One scan with En dropped after start; checks Sel/Busy every cycle.
    // gk: cycle index (after scan-start edge) during which Y is forced low, -1 for none.
    task automatic run_scan(input logic [3:0] m, input int d, input logic [3:0] fexp,
                            input int gk, input string tag);
        int lst[4];
        int n;
        int lat;
        int es;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                lst[n] = i;
                n++;
            end
        end
        lat   = n * (d + 1) + 1;
        Mask  = m;
        Dwell = DW'(d);
        En    = 1'b1;
        push_exp(fexp, cyc + 1 + lat);
        for (int k = 0; k <= lat; k++) begin
            step();
            if (k == 0) En = 1'b0;
            y_force = (k == gk);
            es = (k < lat - 1) ? lst[k / (d + 1)] : lst[n - 1];
            chk({tag, "_sel"}, int'(Sel), es);
            chk({tag, "_busy"}, int'(Busy), (k < lat) ? 1 : 0);
        end
        y_force = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        En      = 1'b0;
        Mask    = 4'b0000;
        Dwell   = '0;
        ch_data = 4'b0000;
        y_force = 1'b0;

        // Reset values
        repeat (3) step();
        chk("rst_sel", int'(Sel), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_frame", int'(Frame), 0);
        chk("rst_vld", int'(Frame_vld), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("idle_busy", int'(Busy), 0);
            chk("idle_sel", int'(Sel), 0);
        end

        // En with empty mask stays idle
        En   = 1'b1;
        Mask = 4'b0000;
        repeat (3) step();
        chk("mask0_busy", int'(Busy), 0);
        chk("mask0_frame", int'(Frame), 0);
        En = 1'b0;
        step();

        // Full scan, dwell 0: A..D = 1,0,1,1
        ch_data = 4'b1101;
        run_scan(4'b1111, 0, 4'b1101, -1, "full");
        step();

        // Sparse mask, dwell 3; unselected channels carry 1 on A to expose leaks
        ch_data = 4'b1011;
        run_scan(4'b1010, 3, 4'b1010, -1, "sparse");
        step();

        // Mask and En changed during channel 1 of a full scan
        ch_data = 4'b0110;
        Mask    = 4'b1111;
        Dwell   = DW'(1);
        En      = 1'b1;
        push_exp(4'b0110, cyc + 1 + 9);
        for (int k = 0; k <= 9; k++) begin
            step();
            if (k == 2) begin
                Mask = 4'b0001;
                En   = 1'b0;
            end
            chk("mid_sel", int'(Sel), (k < 8) ? (k / 2) : 3);
            chk("mid_busy", int'(Busy), (k < 9) ? 1 : 0);
        end
        repeat (8) step();
        chk("mid_idle_busy", int'(Busy), 0);
        chk("mid_frame_hold", int'(Frame), 4'b0110);

        // Single channel, continuous: a frame every dwell+2 cycles
        ch_data = 4'b0100;
        Mask    = 4'b0100;
        Dwell   = DW'(2);
        En      = 1'b1;
        push_exp(4'b0100, cyc + 1 + 4);
        push_exp(4'b0000, cyc + 1 + 8);
        push_exp(4'b0100, cyc + 1 + 12);
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 4)  ch_data = 4'b0000;
            if (k == 8)  ch_data = 4'b0100;
            if (k == 11) En = 1'b0;
            chk("single_sel", int'(Sel), 2);
            chk("single_busy", int'(Busy), (k < 12) ? 1 : 0);
        end
        step();

        // Reset while Sel=2: partial scan discarded
        ch_data = 4'b1111;
        Mask    = 4'b1111;
        Dwell   = DW'(2);
        En      = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 0) En = 1'b0;
        end
        chk("pre_rst_sel", int'(Sel), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_sel", int'(Sel), 0);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_frame", int'(Frame), 0);
        chk("midrst_vld", int'(Frame_vld), 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (8) step();
        chk("postrst_busy", int'(Busy), 0);
        chk("postrst_frame", int'(Frame), 0);

        // Fresh scan after reset
        run_scan(4'b0101, 0, 4'b0101, -1, "recover");
        step();

        // Sampling: glitch on last dwell cycle, glitch mid-window, short dwell fallback
        ch_data = 4'b0001;
`ifdef MUX_SEQ_MAJORITY_EN
        run_scan(4'b0001, 4, 4'b0001, 4, "glitch_last");
`else
        run_scan(4'b0001, 4, 4'b0000, 4, "glitch_last");
`endif
        step();
        run_scan(4'b0001, 4, 4'b0001, 3, "glitch_mid");
        step();
        run_scan(4'b0001, 1, 4'b0000, 1, "glitch_short");

        repeat (10) step();
        chk("missing_vld", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
